// File: rtl/mall_door_decoder.sv
// -----------------------------------------------------------------------------
// mall_door_decoder
// Decodes the direction of a person passing a doorway guarded by two
// beam-break sensors (outer A, inner B). Each raw sensor is synchronized,
// debounced, and the filtered pair drives a crossing-sequence FSM that pulses
// enter / leave on a completed crossing, or timeout when a crossing stalls.
//
// Ports:
//   clock    - system clock, all state on rising edge
//   reset    - asynchronous active-low reset
//   sens_a   - raw outer sensor, 1 = blocked, asynchronous
//   sens_b   - raw inner sensor, 1 = blocked, asynchronous
//   enter    - one-cycle pulse per outer-to-inner crossing (registered)
//   leave    - one-cycle pulse per inner-to-outer crossing (registered)
//   timeout  - one-cycle pulse when a crossing stalls (registered)
//   busy     - high while the FSM is not in IDLE (registered)
// -----------------------------------------------------------------------------
module mall_door_decoder #(
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic sens_a,
  input  logic sens_b,
  output logic enter,
  output logic leave,
  output logic timeout,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    A1       = 3'd1,
    AB_IN    = 3'd2,
    B_IN     = 3'd3,
    B1       = 3'd4,
    AB_OUT   = 3'd5,
    A_OUT    = 3'd6,
    WAIT_CLR = 3'd7
  } state_t;

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Bit 1 carries sensor A, bit 0 carries sensor B throughout.
  logic [1:0]      sync1_r;
  logic [1:0]      sync2_r;
  logic [1:0]      filt_r;
  logic [1:0]      filt_next_s;
  logic [1:0][3:0] cnt_r;
  logic [1:0][3:0] cnt_next_s;

  state_t          state_r;
  state_t          state_seq_s;
  state_t          state_next_s;
  logic [7:0]      timer_r;
  logic [7:0]      timer_next_s;
  logic            active_s;
  logic            enter_s;
  logic            leave_s;
  logic            timeout_s;
  logic            enter_r;
  logic            leave_r;
  logic            timeout_r;
  logic            busy_r;

  // Two-flop synchronizer for both raw sensors.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= {sens_a, sens_b};
      sync2_r <= sync1_r;
    end
  end

  // Debounce next-state: count cycles of disagreement, flip the filtered
  // level on the DEB_CYCLES-th one. Any agreement restarts the count, so
  // glitches shorter than DEB_CYCLES never reach the filtered level.
  always_comb begin
    filt_next_s = filt_r;
    cnt_next_s  = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_r[i] != filt_r[i]) begin
        if (cnt_r[i] == DEB_LAST) begin
          filt_next_s[i] = ~filt_r[i];
          cnt_next_s[i]  = 4'd0;
        end else begin
          filt_next_s[i] = filt_r[i];
          cnt_next_s[i]  = cnt_r[i] + 4'd1;
        end
      end else begin
        filt_next_s[i] = filt_r[i];
        cnt_next_s[i]  = 4'd0;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_r <= 2'b00;
      cnt_r  <= '0;
    end else begin
      filt_r <= filt_next_s;
      cnt_r  <= cnt_next_s;
    end
  end

  // Sequence next-state. The FSM reacts to the filtered level being loaded
  // this edge, so the FSM and the filtered level update together and the
  // registered pulses appear in the same cycle the filtered edge does.
  always_comb begin
    state_seq_s = state_r;
    enter_s     = 1'b0;
    leave_s     = 1'b0;
    case (state_r)
      IDLE: begin
        case (filt_next_s)
          2'b10:   state_seq_s = A1;
          2'b01:   state_seq_s = B1;
          2'b11:   state_seq_s = WAIT_CLR;
          default: state_seq_s = IDLE;
        endcase
      end
      A1: begin
        case (filt_next_s)
          2'b11:   state_seq_s = AB_IN;
          2'b00:   state_seq_s = IDLE;
          2'b01:   state_seq_s = WAIT_CLR;
          default: state_seq_s = A1;
        endcase
      end
      AB_IN: begin
        case (filt_next_s)
          2'b01:   state_seq_s = B_IN;
          2'b10:   state_seq_s = A1;
          2'b00:   state_seq_s = WAIT_CLR;
          default: state_seq_s = AB_IN;
        endcase
      end
      B_IN: begin
        case (filt_next_s)
          2'b00: begin
            state_seq_s = IDLE;
            enter_s     = 1'b1;
          end
          2'b11:   state_seq_s = AB_IN;
          2'b10:   state_seq_s = WAIT_CLR;
          default: state_seq_s = B_IN;
        endcase
      end
      B1: begin
        case (filt_next_s)
          2'b11:   state_seq_s = AB_OUT;
          2'b00:   state_seq_s = IDLE;
          2'b10:   state_seq_s = WAIT_CLR;
          default: state_seq_s = B1;
        endcase
      end
      AB_OUT: begin
        case (filt_next_s)
          2'b10:   state_seq_s = A_OUT;
          2'b01:   state_seq_s = B1;
          2'b00:   state_seq_s = WAIT_CLR;
          default: state_seq_s = AB_OUT;
        endcase
      end
      A_OUT: begin
        case (filt_next_s)
          2'b00: begin
            state_seq_s = IDLE;
            leave_s     = 1'b1;
          end
          2'b11:   state_seq_s = AB_OUT;
          2'b01:   state_seq_s = WAIT_CLR;
          default: state_seq_s = A_OUT;
        endcase
      end
      WAIT_CLR: begin
        if (filt_next_s == 2'b00) begin
          state_seq_s = IDLE;
        end else begin
          state_seq_s = WAIT_CLR;
        end
      end
      default: state_seq_s = IDLE;
    endcase
  end

  // Timeout override: only fires when the sequence is not already moving,
  // so a completion (or any other transition) on the expiry cycle wins.
  always_comb begin
    active_s = (state_r != IDLE) && (state_r != WAIT_CLR);
    if (active_s && (state_seq_s == state_r) && (timer_r == TMO_LAST)) begin
      state_next_s = WAIT_CLR;
      timeout_s    = 1'b1;
    end else begin
      state_next_s = state_seq_s;
      timeout_s    = 1'b0;
    end
  end

  // Crossing timer: restarts on every state change, runs in sequence states.
  always_comb begin
    if (state_next_s != state_r) begin
      timer_next_s = 8'd0;
    end else if (active_s) begin
      timer_next_s = timer_r + 8'd1;
    end else begin
      timer_next_s = 8'd0;
    end
  end

  // FSM, timer and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      timer_r   <= 8'd0;
      enter_r   <= 1'b0;
      leave_r   <= 1'b0;
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      timer_r   <= timer_next_s;
      enter_r   <= enter_s;
      leave_r   <= leave_s;
      timeout_r <= timeout_s;
      busy_r    <= (state_next_s != IDLE);
    end
  end

  assign enter   = enter_r;
  assign leave   = leave_r;
  assign timeout = timeout_r;
  assign busy    = busy_r;

endmodule
